// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   NUM_REQ  requesters sharing the bus (fetch, load, store)
//   ADDR_W   address width
//   DATA_W   bus data width
//   ID_W     bus id width, $clog2(NUM_REQ)
package mem_arb_pkg;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned ID_W    = $clog2(NUM_REQ);

   localparam int unsigned REQ_FETCH = 0;
   localparam int unsigned REQ_LOAD  = 1;
   localparam int unsigned REQ_STORE = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RESP,
      DELIVER
   } arb_state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // Successor of a requester id, wrapping NUM_REQ-1 back to 0.
   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
   endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req_valid  in   requesters asking for the bus
//   rr_ptr     in   requester with the highest priority this round
//   grant      out  one-hot winner (zero when nobody asks)
//   grant_id   out  winner index
//   any        out  at least one requester is asking
module rr_picker
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any
);

   logic [ID_W-1:0] idx;

   // Scan rr_ptr, rr_ptr+1, ... and take the first asserted request.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = rr_ptr;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!any && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = idx;
            any        = 1'b1;
         end
         idx = next_id(idx);
      end
   end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one memory bus among fetch, load and store requesters, round-robin,
// with exactly one transaction outstanding; responses are routed by bus id.
//   clk, reset                  clock, async active-high reset
//   req_valid/write/addr/wdata  per-requester request (slice i = requester i)
//   req_ready                   one-hot accept pulse (combinational, IDLE only)
//   resp_valid/resp_data        one-hot response to the owner, held until resp_ready
//   resp_ready                  per-requester response consume
//   mem_req_*                   transaction to memory, tagged with owner id
//   mem_resp_*                  response from memory, id echoed
//   busy                        arbiter not idle
//   id_error                    sticky: a response carried a foreign id
module memory_bus_arbiter
   import mem_arb_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   input  logic [NUM_REQ-1:0]        resp_ready,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_write,
   output logic [ADDR_W-1:0]         mem_req_addr,
   output logic [DATA_W-1:0]         mem_req_wdata,
   output logic [ID_W-1:0]           mem_req_id,
   input  logic                      mem_resp_valid,
   input  logic [ID_W-1:0]           mem_resp_id,
   input  logic [DATA_W-1:0]         mem_resp_data,
   output logic                      mem_resp_ready,
   output logic                      busy,
   output logic                      id_error
);

   arb_state_t        state_q, state_d;
   mem_req_t          req_q, req_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              id_error_q, id_error_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               any;

   logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
   logic [DATA_W-1:0] wdata_arr [NUM_REQ];

   // Unpack the flat request buses into per-requester slices.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
         wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
      end
   end

   rr_picker u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_id  (grant_id),
      .any       (any)
   );

   // State and latched transaction fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         resp_data_q <= '0;
         id_error_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         resp_data_q <= resp_data_d;
         id_error_q  <= id_error_d;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      owner_d        = owner_q;
      rr_ptr_d       = rr_ptr_q;
      resp_data_d    = resp_data_q;
      id_error_d     = id_error_q;
      req_ready      = '0;
      resp_valid     = '0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;

      case (state_q)
         IDLE: begin
            if (any) begin
               // Accept pulse is combinational; gated so it reads 0 during reset.
               if (!reset) begin
                  req_ready = grant;
               end
               req_d.write = req_write[grant_id];
               req_d.addr  = addr_arr[grant_id];
               req_d.wdata = wdata_arr[grant_id];
               owner_d     = grant_id;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            mem_resp_ready = 1'b1;
            if (mem_resp_valid) begin
               if (mem_resp_id == owner_q) begin
                  // A write ack returns zero regardless of the bus data.
                  resp_data_d = req_q.write ? '0 : mem_resp_data;
                  state_d     = DELIVER;
               end else begin
                  id_error_d = 1'b1;
               end
            end
         end
         DELIVER: begin
            resp_valid[owner_q] = 1'b1;
            if (resp_ready[owner_q]) begin
               rr_ptr_d = next_id(owner_q);
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_req_write = req_q.write;
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wdata = req_q.wdata;
   assign mem_req_id    = owner_q;
   assign resp_data     = resp_data_q;
   assign busy          = (state_q != IDLE);
   assign id_error      = id_error_q;

endmodule
